// File: rtl/peripheral_adder_arbiter.sv
// peripheral_adder_arbiter
//
// Shares one external adder between NUM_REQ requesters. A round-robin arbiter
// picks a requester, its operands are registered onto add_ip1/add_ip2, the
// block waits ADD_LAT cycles, captures add_out and returns it together with
// the requester index on a valid/ready response channel. Only one operation
// is in flight at a time.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept (one-hot or zero, combinational)
//   req_ip1    packed operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ip2    packed operand B, same packing
//   add_ip1    registered operand A to the shared adder
//   add_ip2    registered operand B to the shared adder
//   add_out    adder result (DATA_WIDTH+1 bits)
//   rsp_valid  response valid
//   rsp_ready  response accept
//   rsp_id     requester index the response belongs to
//   rsp_data   captured sum, carry in MSB
//   busy       high whenever the FSM is not idle
//
// Build option:
//   PERIPHERAL_ADDER_ARBITER_BACK2BACK_EN - when defined, the response cycle
//   is also an accept cycle while rsp_ready=1, so a new operation can start
//   on the same edge the previous response completes.

module peripheral_adder_arbiter #(
   parameter int  NUM_REQ    = 4,
   parameter int  DATA_WIDTH = 8,
   parameter int  ADD_LAT    = 1,
   localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_ip1,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_ip2,
   output logic [DATA_WIDTH-1:0]         add_ip1,
   output logic [DATA_WIDTH-1:0]         add_ip2,
   input  logic [DATA_WIDTH:0]           add_out,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_W-1:0]               rsp_id,
   output logic [DATA_WIDTH:0]           rsp_data,
   output logic                          busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] LAT_INIT = 4'(ADD_LAT - 1);

   state_t                state_reg;
   logic [ID_W-1:0]       rr_ptr_reg;
   logic [3:0]            lat_cnt_reg;
   logic [DATA_WIDTH-1:0] add_ip1_reg;
   logic [DATA_WIDTH-1:0] add_ip2_reg;
   logic [ID_W-1:0]       rsp_id_reg;
   logic [DATA_WIDTH:0]   rsp_data_reg;
   logic                  rsp_valid_reg;

   logic [ID_W-1:0]       cand_idx [NUM_REQ];
   logic [DATA_WIDTH-1:0] ip1_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] ip2_arr  [NUM_REQ];
   logic                  grant_found;
   logic [ID_W-1:0]       grant_idx;
   logic [ID_W-1:0]       rr_next;
   logic [DATA_WIDTH-1:0] grant_ip1;
   logic [DATA_WIDTH-1:0] grant_ip2;
   logic                  accept_cycle;
   logic                  take;

   // Candidate k of the round-robin search is (rr_ptr + k) mod NUM_REQ; a
   // single conditional subtract is enough because both terms are < NUM_REQ.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [ID_W:0] pos;
      assign pos           = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
      assign cand_idx[gi]  = (pos >= (ID_W+1)'(NUM_REQ)) ?
                             ID_W'(pos - (ID_W+1)'(NUM_REQ)) : pos[ID_W-1:0];
      assign ip1_arr[gi]   = req_ip1[gi*DATA_WIDTH +: DATA_WIDTH];
      assign ip2_arr[gi]   = req_ip2[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // Walk candidates from the farthest to the nearest so the nearest valid
   // requester is the last (and therefore winning) assignment.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[cand_idx[k]]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx[k];
         end
      end
   end

   assign grant_ip1 = ip1_arr[grant_idx];
   assign grant_ip2 = ip2_arr[grant_idx];
   assign rr_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

`ifdef PERIPHERAL_ADDER_ARBITER_BACK2BACK_EN
   assign accept_cycle = (state_reg == S_IDLE) || ((state_reg == S_RESP) && rsp_ready);
`else
   assign accept_cycle = (state_reg == S_IDLE);
`endif

   // rst gates the handshake so nothing is accepted while reset is held.
   assign take = accept_cycle && grant_found && rst;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = take && (grant_idx == ID_W'(gi));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= S_IDLE;
         rr_ptr_reg    <= '0;
         lat_cnt_reg   <= '0;
         add_ip1_reg   <= '0;
         add_ip2_reg   <= '0;
         rsp_id_reg    <= '0;
         rsp_data_reg  <= '0;
         rsp_valid_reg <= 1'b0;
      end else begin
         // Operand load is shared by every accept cycle (IDLE, or RESP when
         // back-to-back is enabled); take can only be high in those states.
         if (take) begin
            add_ip1_reg <= grant_ip1;
            add_ip2_reg <= grant_ip2;
            rsp_id_reg  <= grant_idx;
            rr_ptr_reg  <= rr_next;
            lat_cnt_reg <= LAT_INIT;
         end
         case (state_reg)
            S_IDLE: begin
               if (take) state_reg <= S_WAIT;
            end
            S_WAIT: begin
               if (lat_cnt_reg == 4'd0) begin
                  rsp_data_reg  <= add_out;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= S_RESP;
               end else begin
                  lat_cnt_reg <= lat_cnt_reg - 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= take ? S_WAIT : S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign add_ip1   = add_ip1_reg;
   assign add_ip2   = add_ip2_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_id    = rsp_id_reg;
   assign rsp_data  = rsp_data_reg;
   assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_peripheral_adder_arbiter.sv
// Testbench for peripheral_adder_arbiter: one instance with ADD_LAT=1 checked
// every cycle against a timing-level model, one with ADD_LAT=3 driven by
// directed vectors, plus literal expectations at the interesting cycles.
module tb_peripheral_adder_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int L1 = 1;
`ifdef PERIPHERAL_ADDER_ARBITER_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif
   localparam int GAP = B2B ? 2 : 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // instance with ADD_LAT=1 and a combinational adder
   logic [N-1:0]   req_valid = '0, req_ready;
   logic [N*W-1:0] req_ip1 = '0, req_ip2 = '0;
   logic [W-1:0]   add_ip1, add_ip2;
   logic [W:0]     add_out, rsp_data;
   logic           rsp_valid, rsp_ready = 1'b0, busy;
   logic [1:0]     rsp_id;
   assign add_out = {1'b0, add_ip1} + {1'b0, add_ip2};

   peripheral_adder_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .ADD_LAT(L1)) dut (
      .clk(clk), .rst(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_ip1(req_ip1), .req_ip2(req_ip2), .add_ip1(add_ip1), .add_ip2(add_ip2),
      .add_out(add_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy));

   // instance with ADD_LAT=3; add_out driven directly by the stimulus
   logic [N-1:0]   req_valid_l3 = '0, req_ready_l3;
   logic [N*W-1:0] req_ip1_l3 = '0, req_ip2_l3 = '0;
   logic [W-1:0]   add_ip1_l3, add_ip2_l3;
   logic [W:0]     add_out_l3 = '0, rsp_data_l3;
   logic           rsp_valid_l3, rsp_ready_l3 = 1'b1, busy_l3;
   logic [1:0]     rsp_id_l3;

   peripheral_adder_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .ADD_LAT(3)) dut_l3 (
      .clk(clk), .rst(rst_n), .req_valid(req_valid_l3), .req_ready(req_ready_l3),
      .req_ip1(req_ip1_l3), .req_ip2(req_ip2_l3), .add_ip1(add_ip1_l3),
      .add_ip2(add_ip2_l3), .add_out(add_out_l3), .rsp_valid(rsp_valid_l3),
      .rsp_ready(rsp_ready_l3), .rsp_id(rsp_id_l3), .rsp_data(rsp_data_l3),
      .busy(busy_l3));

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- behavioural model (ADD_LAT=1 instance) ----------------
   // An operation is "held" from the edge that accepts it until the edge its
   // response is taken; m_age counts cycles since acceptance.
   bit         m_have = 1'b0;
   int         m_age  = 0;
   int         m_rr   = 0;
   int         m_id   = 0;
   logic [W-1:0] m_ip1 = '0, m_ip2 = '0;
   logic [W:0]   m_sum = '0, m_data = '0;
   bit         e_rv, acc_ok, g_found;
   int         g_idx;
   logic [N-1:0] e_ready;

   always_comb begin
      e_rv    = m_have && (m_age >= L1);
      acc_ok  = !m_have || (B2B && e_rv && rsp_ready);
      g_found = 1'b0;
      g_idx   = 0;
      for (int k = 0; k < N; k++) begin
         if (!g_found && req_valid[(m_rr + k) % N]) begin
            g_found = 1'b1;
            g_idx   = (m_rr + k) % N;
         end
      end
      e_ready = '0;
      if (rst_n && acc_ok && g_found) e_ready[g_idx] = 1'b1;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_have <= 1'b0; m_age <= 0; m_rr <= 0; m_id <= 0;
         m_ip1 <= '0; m_ip2 <= '0; m_sum <= '0; m_data <= '0;
      end else begin
         if (m_have && !e_rv && m_age == L1 - 1) m_data <= m_sum;
         if (m_have) m_age <= m_age + 1;
         if (e_rv && rsp_ready) m_have <= 1'b0;
         if (e_ready != '0) begin
            m_have <= 1'b1;
            m_age  <= 0;
            m_id   <= g_idx;
            m_ip1  <= req_ip1[g_idx*W +: W];
            m_ip2  <= req_ip2[g_idx*W +: W];
            m_sum  <= {1'b0, req_ip1[g_idx*W +: W]} + {1'b0, req_ip2[g_idx*W +: W]};
            m_rr   <= (g_idx + 1) % N;
         end
      end
   end

   always @(negedge clk) begin
      check("cyc req_ready", 32'(req_ready), 32'(e_ready));
      check("cyc add_ip1",   32'(add_ip1),   32'(m_ip1));
      check("cyc add_ip2",   32'(add_ip2),   32'(m_ip2));
      check("cyc rsp_valid", 32'(rsp_valid), 32'(e_rv));
      check("cyc rsp_id",    32'(rsp_id),    32'(m_id));
      check("cyc rsp_data",  32'(rsp_data),  32'(m_data));
      check("cyc busy",      32'(busy),      32'(m_have));
   end

   // ---------------- transaction monitor ----------------
   int acc_id_q[$], acc_cyc_q[$], rsp_id_q[$], rsp_data_q[$], rsp_cyc_q[$];
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               acc_id_q.push_back(i);
               acc_cyc_q.push_back(cyc);
               $display("cycle %0d: accept requester %0d", cyc, i);
            end
         end
         if (rsp_valid && rsp_ready) begin
            rsp_id_q.push_back(int'(rsp_id));
            rsp_data_q.push_back(int'(rsp_data));
            rsp_cyc_q.push_back(cyc);
            $display("cycle %0d: response id %0d data %03h", cyc, rsp_id, rsp_data);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      acc_id_q.delete(); acc_cyc_q.delete();
      rsp_id_q.delete(); rsp_data_q.delete(); rsp_cyc_q.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      clear_q();
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_ip1[i*W +: W] = a;
      req_ip2[i*W +: W] = b;
   endtask

   int exp_order[6] = '{0, 1, 2, 3, 0, 1};
   int exp_sum[4]   = '{32'h051, 32'h091, 32'h0D1, 32'h111};

   initial begin
      #2;
      do_reset();

      // 1: FF + 01 from requester 0
      set_op(0, 8'hFF, 8'h01); rsp_ready = 1'b1; req_valid = 4'b0001;
      @(negedge clk); check("t1 req_ready", 32'(req_ready), 32'h1);
      step(); req_valid = '0;
      @(negedge clk); check("t1 add_ip1", 32'(add_ip1), 32'hFF);
                      check("t1 add_ip2", 32'(add_ip2), 32'h01);
                      check("t1 wait rsp_valid", 32'(rsp_valid), 32'h0);
      step();
      @(negedge clk); check("t1 rsp_valid", 32'(rsp_valid), 32'h1);
                      check("t1 rsp_data", 32'(rsp_data), 32'h100);
                      check("t1 rsp_id", 32'(rsp_id), 32'h0);
      step();
      @(negedge clk); check("t1 busy", 32'(busy), 32'h0);

      // 2: all requesters valid, round-robin order and spacing
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, W'(64 * i + 1), 8'h50);
      req_valid = 4'hF; rsp_ready = 1'b1;
      for (int n = 0; n < 60 && acc_id_q.size() < 6; n++) step();
      req_valid = '0;
      for (int n = 0; n < 20 && rsp_id_q.size() < 6; n++) step();
      check("t2 n_accepts", 32'(acc_id_q.size()), 32'd6);
      check("t2 n_responses", 32'(rsp_id_q.size()), 32'd6);
      for (int k = 0; k < 6 && k < acc_id_q.size(); k++) begin
         check("t2 grant_id", 32'(acc_id_q[k]), 32'(exp_order[k]));
         if (k > 0) check("t2 accept_gap", 32'(acc_cyc_q[k] - acc_cyc_q[k-1]), 32'(GAP));
      end
      for (int k = 0; k < 4 && k < rsp_id_q.size(); k++) begin
         check("t2 rsp_id", 32'(rsp_id_q[k]), 32'(k));
         check("t2 rsp_data", 32'(rsp_data_q[k]), 32'(exp_sum[k]));
      end

      // 3: response backpressure for 5 cycles
      do_reset();
      rsp_ready = 1'b0; set_op(2, 8'h12, 8'h34); req_valid = 4'b0100;
      @(negedge clk); check("t3 req_ready", 32'(req_ready), 32'h4);
      step(); req_valid = 4'b1011;
      step();
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check("t3 stall rsp_valid", 32'(rsp_valid), 32'h1);
         check("t3 stall rsp_id", 32'(rsp_id), 32'h2);
         check("t3 stall rsp_data", 32'(rsp_data), 32'h046);
         check("t3 stall req_ready", 32'(req_ready), 32'h0);
         step();
      end
      rsp_ready = 1'b1; req_valid = '0;
      @(negedge clk); check("t3 release rsp_valid", 32'(rsp_valid), 32'h1);
      step();
      @(negedge clk); check("t3 idle busy", 32'(busy), 32'h0);
                      check("t3 idle rsp_valid", 32'(rsp_valid), 32'h0);
      repeat (2) step();
      check("t3 n_responses", 32'(rsp_id_q.size()), 32'd1);

      // 4: ADD_LAT=3, add_out garbage in the first two WAIT cycles
      do_reset();
      req_ip1_l3[1*W +: W] = 8'h80; req_ip2_l3[1*W +: W] = 8'h80;
      rsp_ready_l3 = 1'b1; req_valid_l3 = 4'b0010; add_out_l3 = 9'h1FF;
      @(negedge clk); check("t4 req_ready", 32'(req_ready_l3), 32'h2);
      step(); req_valid_l3 = '0; add_out_l3 = 9'h0AA;
      @(negedge clk); check("t4 add_ip1", 32'(add_ip1_l3), 32'h80);
                      check("t4 busy", 32'(busy_l3), 32'h1);
      step(); add_out_l3 = 9'h155;
      step(); add_out_l3 = 9'h100;
      @(negedge clk); check("t4 early rsp_valid", 32'(rsp_valid_l3), 32'h0);
      step(); add_out_l3 = 9'h0FF;
      @(negedge clk); check("t4 rsp_valid", 32'(rsp_valid_l3), 32'h1);
                      check("t4 rsp_data", 32'(rsp_data_l3), 32'h100);
                      check("t4 rsp_id", 32'(rsp_id_l3), 32'h1);
      step();
      @(negedge clk); check("t4 busy end", 32'(busy_l3), 32'h0);

      // 5: reset during WAIT drops the operation
      do_reset();
      rsp_ready = 1'b1; set_op(3, 8'h0F, 8'h0F); req_valid = 4'b1000;
      @(negedge clk); check("t5 req_ready", 32'(req_ready), 32'h8);
      step();
      rst_n = 1'b0;
      #1;
      check("t5 rst add_ip1", 32'(add_ip1), 32'h0);
      check("t5 rst add_ip2", 32'(add_ip2), 32'h0);
      check("t5 rst rsp_id", 32'(rsp_id), 32'h0);
      check("t5 rst rsp_data", 32'(rsp_data), 32'h0);
      check("t5 rst rsp_valid", 32'(rsp_valid), 32'h0);
      check("t5 rst busy", 32'(busy), 32'h0);
      check("t5 rst req_ready", 32'(req_ready), 32'h0);
      repeat (2) step();
      rst_n = 1'b1; req_valid = '0; clear_q();
      repeat (4) step();
      check("t5 no response", 32'(rsp_id_q.size()), 32'd0);
      req_valid = 4'b1001;
      @(negedge clk); check("t5 regrant", 32'(req_ready), 32'h1);
      step(); req_valid = '0;
      repeat (3) step();

      // 6: two requesters, spacing with or without back-to-back
      do_reset();
      set_op(0, 8'h01, 8'h02); set_op(1, 8'h03, 8'h04);
      req_valid = 4'b0011; rsp_ready = 1'b1;
      for (int n = 0; n < 20 && acc_id_q.size() < 2; n++) step();
      req_valid = '0;
      repeat (4) step();
      check("t6 n_accepts", 32'(acc_id_q.size()), 32'd2);
      if (acc_id_q.size() >= 2 && rsp_id_q.size() >= 1) begin
         check("t6 first id", 32'(acc_id_q[0]), 32'h0);
         check("t6 second id", 32'(acc_id_q[1]), 32'h1);
         check("t6 accept_gap", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'(GAP));
         check("t6 rsp_to_accept", 32'(acc_cyc_q[1] - rsp_cyc_q[0]), 32'(GAP - 2));
         check("t6 rsp_data", 32'(rsp_data_q[0]), 32'h003);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
